ccd_pixel_sampler: RTL and testbench

- Receive-side companion to the CCD clock generator (phi_p, phi_l1, phi_l2, phi_r).
- Watches the same phase signals and sequences correlated double sampling (CDS) of the CCD output through an external ADC data bus.
- Per pixel: captures the reset level, then the signal level, and emits difference = reset − signal with pixel index and line framing.
- Checks the incoming phase protocol and raises sticky error flags.

---
 rtl/ccd_pixel_sampler.sv | 192 +++++++++++++++++++
 tb/tb_ccd_pixel_sampler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_pixel_sampler.sv
// Receive-side CDS sequencer for a CCD output stage. Follows the phase signals from the clock
// generator, captures reset/signal levels from the ADC and emits framed difference pixels.
module ccd_pixel_sampler #(
  parameter int unsigned ADC_W   = 12,
  parameter int unsigned PIXELS  = 4,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned RST_DLY = 1,
  parameter int unsigned SIG_DLY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phi_p,
  input  logic             phi_l1,
  input  logic             phi_l2,
  input  logic             phi_r,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             err_clr,
  output logic             pix_valid,
  output logic [ADC_W-1:0] pix_data,
  output logic [IDX_W-1:0] pix_idx,
  output logic             line_start,
  output logic             line_done,
  output logic             sample_rst,
  output logic             sample_sig,
  output logic             overlap_err,
  output logic             seq_err,
  output logic             count_err
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitR,
    StDlyR,
    StWaitS,
    StDlyS
  } state_e;

  localparam logic [IDX_W-1:0] PixLast = IDX_W'(PIXELS);
  localparam logic [3:0]       RstDly  = 4'(RST_DLY);
  localparam logic [3:0]       SigDly  = 4'(SIG_DLY);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       dly_q, dly_d;
  logic [ADC_W-1:0] ref_q, ref_d;

  logic             phi_p_q, phi_l2_q, phi_r_q;
  logic             p_rise, l2_fall, r_fall;

  logic             pix_valid_d, line_start_d, line_done_d, sample_rst_d, sample_sig_d;
  logic [ADC_W-1:0] pix_data_d;
  logic [IDX_W-1:0] pix_idx_d;
  logic             seq_set, count_set, overlap_set;
  logic             overlap_d, seq_d, count_d;

  // Edges compare the live input with its one-cycle-old copy.
  assign p_rise  = phi_p & ~phi_p_q;
  assign l2_fall = ~phi_l2 & phi_l2_q;
  assign r_fall  = ~phi_r & phi_r_q;
  assign cnt_inc = cnt_q + IDX_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dly_d        = dly_q;
    ref_d        = ref_q;
    pix_valid_d  = 1'b0;
    pix_data_d   = pix_data;
    pix_idx_d    = pix_idx;
    line_start_d = 1'b0;
    line_done_d  = 1'b0;
    sample_rst_d = 1'b0;
    sample_sig_d = 1'b0;
    seq_set      = 1'b0;
    count_set    = 1'b0;

    // A line start mid-line beats any simultaneous phi_r / phi_l2 event.
    if (state_q != StIdle && p_rise) begin
      count_set    = (cnt_q != PixLast);
      line_start_d = 1'b1;
      cnt_d        = '0;
      state_d      = StWaitR;
    end else begin
      case (state_q)
        StIdle: begin
          if (p_rise) begin
            line_start_d = 1'b1;
            cnt_d        = '0;
            state_d      = StWaitR;
          end
        end
        StWaitR: begin
          if (l2_fall) begin
            seq_set = 1'b1;
          end else if (r_fall) begin
            dly_d   = RstDly;
            state_d = StDlyR;
          end
        end
        StDlyR: begin
          if (l2_fall) begin
            seq_set = 1'b1;
            state_d = StWaitR;
          end else if (dly_q == 4'd0) begin
            sample_rst_d = 1'b1;
            ref_d        = adc_data;
            state_d      = StWaitS;
          end else begin
            dly_d = dly_q - 4'd1;
          end
        end
        StWaitS: begin
          if (r_fall) begin
            seq_set = 1'b1;
            state_d = StWaitR;
          end else if (l2_fall) begin
            dly_d   = SigDly;
            state_d = StDlyS;
          end
        end
        StDlyS: begin
          if (r_fall) begin
            seq_set = 1'b1;
            state_d = StWaitR;
          end else if (dly_q == 4'd0) begin
            sample_sig_d = 1'b1;
            pix_valid_d  = 1'b1;
            pix_data_d   = (adc_data > ref_q) ? '0 : (ref_q - adc_data);
            pix_idx_d    = cnt_q;
            cnt_d        = cnt_inc;
            if (cnt_inc == PixLast) begin
              line_done_d = 1'b1;
              state_d     = StIdle;
            end else begin
              state_d = StWaitR;
            end
          end else begin
            dly_d = dly_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as err_clr wins.
  assign overlap_set = phi_l1 & phi_l2;
  assign overlap_d   = overlap_set | (overlap_err & ~err_clr);
  assign seq_d       = seq_set | (seq_err & ~err_clr);
  assign count_d     = count_set | (count_err & ~err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dly_q       <= '0;
      ref_q       <= '0;
      phi_p_q     <= 1'b0;
      phi_l2_q    <= 1'b0;
      phi_r_q     <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_idx     <= '0;
      line_start  <= 1'b0;
      line_done   <= 1'b0;
      sample_rst  <= 1'b0;
      sample_sig  <= 1'b0;
      overlap_err <= 1'b0;
      seq_err     <= 1'b0;
      count_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      ref_q       <= ref_d;
      phi_p_q     <= phi_p;
      phi_l2_q    <= phi_l2;
      phi_r_q     <= phi_r;
      pix_valid   <= pix_valid_d;
      pix_data    <= pix_data_d;
      pix_idx     <= pix_idx_d;
      line_start  <= line_start_d;
      line_done   <= line_done_d;
      sample_rst  <= sample_rst_d;
      sample_sig  <= sample_sig_d;
      overlap_err <= overlap_d;
      seq_err     <= seq_d;
      count_err   <= count_d;
    end
  end

endmodule

// File: tb/tb_ccd_pixel_sampler.sv
// Directed bench for ccd_pixel_sampler: nominal line, delay timing, saturation, early line start,
// protocol faults and reset mid-pixel.
module tb_ccd_pixel_sampler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        phi_p, phi_l1, phi_l2, phi_r, err_clr;
  logic [11:0] adc_data;
  logic        pix_valid, line_start, line_done, sample_rst, sample_sig;
  logic        overlap_err, seq_err, count_err;
  logic [11:0] pix_data;
  logic [7:0]  pix_idx;

  int checks = 0;
  int errors = 0;

  int pv_cnt = 0, ls_cnt = 0, ld_cnt = 0, sr_cnt = 0, ss_cnt = 0;
  int ld_idx = 0;
  int pv_data[64];
  int pv_idx[64];
  int pv0, sr0, ls0;

  ccd_pixel_sampler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .phi_p      (phi_p),
    .phi_l1     (phi_l1),
    .phi_l2     (phi_l2),
    .phi_r      (phi_r),
    .adc_data   (adc_data),
    .err_clr    (err_clr),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_idx    (pix_idx),
    .line_start (line_start),
    .line_done  (line_done),
    .sample_rst (sample_rst),
    .sample_sig (sample_sig),
    .overlap_err(overlap_err),
    .seq_err    (seq_err),
    .count_err  (count_err)
  );

  always #5 clk = ~clk;

  // Event log sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid) begin
        pv_data[pv_cnt & 63] = int'(pix_data);
        pv_idx[pv_cnt & 63]  = int'(pix_idx);
        pv_cnt++;
      end
      if (line_start) ls_cnt++;
      if (line_done) begin
        ld_cnt++;
        ld_idx = int'(pix_idx);
      end
      if (sample_rst) sr_cnt++;
      if (sample_sig) ss_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_line();
    phi_p = 1'b1;
    cycles(2);
    phi_p = 1'b0;
    cycles(2);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
  endtask

  // One pixel of generator-like timing; optionally checks strobe latency cycle by cycle.
  task automatic pixel(input logic [11:0] ref_lvl, input logic [11:0] sig_lvl, input bit timed);
    adc_data = ref_lvl;
    phi_r    = 1'b1;
    cycles(4);
    phi_r = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cycles(1);
      if (timed) check_eq($sformatf("sample_rst_t%0d", i), 32'(sample_rst), 32'(i == 3));
    end
    adc_data = sig_lvl;
    phi_l1   = 1'b0;
    phi_l2   = 1'b1;
    cycles(8);
    phi_l2 = 1'b0;
    phi_l1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cycles(1);
      if (timed) begin
        check_eq($sformatf("sample_sig_t%0d", i), 32'(sample_sig), 32'(i == 4));
        check_eq($sformatf("pix_valid_t%0d", i), 32'(pix_valid), 32'(i == 4));
      end
    end
    phi_l1 = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    phi_p    = 1'b0;
    phi_l1   = 1'b0;
    phi_l2   = 1'b0;
    phi_r    = 1'b0;
    err_clr  = 1'b0;
    adc_data = '0;
    cycles(3);
    check_eq("reset_strobes", 32'({pix_valid, line_start, line_done, sample_rst, sample_sig}), 0);
    check_eq("reset_errs", 32'({overlap_err, seq_err, count_err}), 0);
    check_eq("reset_data", 32'({pix_data, pix_idx}), 0);
    rst_n = 1'b1;
    cycles(2);

    // Overlap in IDLE together with err_clr: set wins; phi_l2 fall in IDLE is ignored.
    phi_l1  = 1'b1;
    phi_l2  = 1'b1;
    err_clr = 1'b1;
    cycles(1);
    phi_l1  = 1'b0;
    phi_l2  = 1'b0;
    err_clr = 1'b0;
    check_eq("overlap_set_wins", 32'(overlap_err), 1);
    cycles(2);
    check_eq("idle_l2_no_seq", 32'(seq_err), 0);
    clear_errs();
    check_eq("overlap_cleared", 32'(overlap_err), 0);

    // Nominal line with delay timing on the first pixel.
    start_line();
    check_eq("nom_line_start", 32'(ls_cnt), 1);
    pixel(12'h300, 12'h100, 1'b1);
    for (int p = 1; p < 4; p++) pixel(12'h300, 12'h100, 1'b0);
    check_eq("nom_pix_count", 32'(pv_cnt), 4);
    for (int p = 0; p < 4; p++) begin
      check_eq($sformatf("nom_idx%0d", p), 32'(pv_idx[p]), 32'(p));
      check_eq($sformatf("nom_data%0d", p), 32'(pv_data[p]), 32'h200);
    end
    check_eq("nom_line_done", 32'(ld_cnt), 1);
    check_eq("nom_done_idx", 32'(ld_idx), 3);
    check_eq("nom_errs", 32'({overlap_err, seq_err, count_err}), 0);

    // Saturation: signal above reset level clamps to zero.
    start_line();
    pixel(12'h100, 12'h180, 1'b0);
    check_eq("sat_pix_count", 32'(pv_cnt), 5);
    check_eq("sat_data", 32'(pv_data[4]), 0);
    check_eq("sat_idx", 32'(pv_idx[4]), 0);

    // Early phi_p after 2 pixels, coincident with a phi_r fall.
    pixel(12'h300, 12'h100, 1'b0);
    sr0    = sr_cnt;
    ls0    = ls_cnt;
    phi_r  = 1'b1;
    cycles(4);
    phi_r = 1'b0;
    phi_p = 1'b1;
    cycles(6);
    phi_p = 1'b0;
    check_eq("early_count_err", 32'(count_err), 1);
    check_eq("early_line_start", 32'(ls_cnt), 32'(ls0 + 1));
    check_eq("early_r_ignored", 32'(sr_cnt), 32'(sr0));
    check_eq("early_no_done", 32'(ld_cnt), 1);
    pixel(12'h280, 12'h080, 1'b0);
    check_eq("early_pix_count", 32'(pv_cnt), 7);
    check_eq("early_next_idx", 32'(pv_idx[6]), 0);
    clear_errs();
    check_eq("count_err_cleared", 32'(count_err), 0);

    // phi_l2 fall while waiting out the reset-level settle delay.
    sr0    = sr_cnt;
    pv0    = pv_cnt;
    phi_r  = 1'b1;
    phi_l2 = 1'b1;
    cycles(4);
    phi_r = 1'b0;
    cycles(1);
    phi_l2 = 1'b0;
    cycles(6);
    check_eq("seq_err_set", 32'(seq_err), 1);
    check_eq("seq_no_sample", 32'(sr_cnt), 32'(sr0));
    check_eq("seq_no_pix", 32'(pv_cnt), 32'(pv0));
    pixel(12'h300, 12'h100, 1'b0);
    check_eq("seq_keep_idx", 32'(pv_idx[7]), 1);
    clear_errs();
    check_eq("seq_err_cleared", 32'(seq_err), 0);

    // Async reset during the signal settle delay.
    phi_r = 1'b1;
    adc_data = 12'h300;
    cycles(4);
    phi_r = 1'b0;
    cycles(6);
    adc_data = 12'h100;
    phi_l2 = 1'b1;
    cycles(8);
    phi_l2 = 1'b0;
    phi_l1 = 1'b1;
    cycles(2);
    pv0   = pv_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_strobes", 32'({pix_valid, line_start, line_done, sample_rst, sample_sig}), 0);
    check_eq("rst_mid_data", 32'({pix_data, pix_idx}), 0);
    phi_l1 = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    sr0 = sr_cnt;
    ls0 = ls_cnt;
    pixel(12'h300, 12'h100, 1'b0);
    check_eq("rst_idle_no_pix", 32'(pv_cnt), 32'(pv0));
    check_eq("rst_idle_no_sample", 32'(sr_cnt), 32'(sr0));
    start_line();
    check_eq("rst_line_start", 32'(ls_cnt), 32'(ls0 + 1));
    pixel(12'h3ff, 12'h001, 1'b0);
    check_eq("rst_pix_idx", 32'(pv_idx[pv0 & 63]), 0);
    check_eq("rst_pix_data", 32'(pv_data[pv0 & 63]), 32'h3fe);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
